// File: rtl/alu_cluster_pkg.sv
// Shared types for the ALU cluster: operation, flag and condition encodings
// plus the ARM-style condition evaluator used by the conditional selects.
package alu_cluster_pkg;

    typedef enum logic [3:0] {
        OP_PLUS  = 4'd0,
        OP_MINUS = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_ORN   = 4'd4,
        OP_EOR   = 4'd5,
        OP_CSEL  = 4'd6,
        OP_CSINC = 4'd7,
        OP_CSINV = 4'd8,
        OP_CSNEG = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_t;

    // Odd encodings are the negation of the even one below them, except AL/NV.
    function automatic logic cond_holds(input cond_t cond, input nzcv_t f);
        logic       base;
        logic [3:0] c;
        c = cond;
        case (c[3:1])
            3'd0:    base = f.z;
            3'd1:    base = f.c;
            3'd2:    base = f.n;
            3'd3:    base = f.v;
            3'd4:    base = f.c & ~f.z;
            3'd5:    base = (f.n == f.v);
            3'd6:    base = ~f.z & (f.n == f.v);
            default: base = 1'b1;
        endcase
        return (c[0] && (c[3:1] != 3'd7)) ? ~base : base;
    endfunction

endpackage

// File: rtl/alu_cluster_exec.sv
// Combinational lane datapath: result, NZCV and condition outcome for one
// registered operation.
module alu_exec
    import alu_cluster_pkg::*;
#(
    parameter int GPR_W = 64
) (
    input  alu_op_t            op_i,
    input  logic [GPR_W-1:0]   a_i,
    input  logic [GPR_W-1:0]   b_i,
    input  logic               set_nzcv_i,
    input  nzcv_t              nzcv_i,
    input  cond_t              cond_i,
    output logic [GPR_W-1:0]   result_o,
    output nzcv_t              nzcv_o,
    output logic               cond_holds_o
);
    localparam int M = GPR_W - 1;

    logic [GPR_W:0] sum;
    logic           holds, is_cs, c_f, v_f;

    always_comb begin
        holds    = cond_holds(cond_i, nzcv_i);
        sum      = '0;
        c_f      = 1'b0;
        v_f      = 1'b0;
        is_cs    = 1'b0;
        result_o = '0;
        case (op_i)
            OP_PLUS: begin
                sum      = {1'b0, a_i} + {1'b0, b_i};
                result_o = sum[M:0];
                c_f      = sum[GPR_W];
                v_f      = (a_i[M] == b_i[M]) && (result_o[M] != a_i[M]);
            end
            OP_MINUS: begin
                // carry out of a + ~b + 1 is the inverted borrow
                sum      = {1'b0, a_i} + {1'b0, ~b_i} + (GPR_W+1)'(1);
                result_o = sum[M:0];
                c_f      = sum[GPR_W];
                v_f      = (a_i[M] != b_i[M]) && (result_o[M] != a_i[M]);
            end
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_ORN:   result_o = a_i | ~b_i;
            OP_EOR:   result_o = a_i ^ b_i;
            OP_CSEL:  begin is_cs = 1'b1; result_o = holds ? a_i : b_i;                 end
            OP_CSINC: begin is_cs = 1'b1; result_o = holds ? a_i : b_i + GPR_W'(1);     end
            OP_CSINV: begin is_cs = 1'b1; result_o = holds ? a_i : ~b_i;                end
            OP_CSNEG: begin is_cs = 1'b1; result_o = holds ? a_i : GPR_W'(0) - b_i;     end
            default:  result_o = '0;
        endcase
        nzcv_o       = set_nzcv_i ? '{n: result_o[M], z: (result_o == '0), c: c_f, v: v_f}
                                  : nzcv_i;
        cond_holds_o = is_cs & holds;
    end

endmodule

// File: rtl/alu_cluster.sv
// NUM_ALU execution lanes (operand register + credit-checked result FIFO)
// merged onto one ROB writeback port by a stall-aware round-robin arbiter.
module alu_cluster
    import alu_cluster_pkg::*;
#(
    parameter int NUM_ALU      = 2,
    parameter int RESULT_DEPTH = 2,
    parameter int GPR_W        = 64,
    parameter int ROB_IDX_W    = 6
) (
    input  logic                                in_clk,
    input  logic                                in_rst_n,
    input  logic                                in_flush,
    input  logic [NUM_ALU-1:0]                  in_rs_alu_start,
    input  alu_op_t [NUM_ALU-1:0]               in_rs_alu_op,
    input  logic [NUM_ALU-1:0][GPR_W-1:0]       in_rs_alu_val_a,
    input  logic [NUM_ALU-1:0][GPR_W-1:0]       in_rs_alu_val_b,
    input  logic [NUM_ALU-1:0][ROB_IDX_W-1:0]   in_rs_alu_dst_rob_index,
    input  logic [NUM_ALU-1:0]                  in_rs_alu_set_nzcv,
    input  nzcv_t [NUM_ALU-1:0]                 in_rs_alu_nzcv,
    input  cond_t [NUM_ALU-1:0]                 in_rs_alu_cond,
    output logic [NUM_ALU-1:0]                  out_rs_alu_ready,
    input  logic                                in_rob_ready,
    output logic                                out_rob_done,
    output logic [ROB_IDX_W-1:0]                out_rob_dst_rob_index,
    output logic [GPR_W-1:0]                    out_rob_value,
    output logic                                out_rob_set_nzcv,
    output nzcv_t                               out_rob_nzcv,
    output logic                                out_rob_cond_holds
);
    localparam int LANE_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
    localparam int PTR_W  = $clog2(RESULT_DEPTH);
    localparam int CNT_W  = $clog2(RESULT_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(RESULT_DEPTH);

    typedef struct packed {
        alu_op_t                op;
        logic [GPR_W-1:0]       a;
        logic [GPR_W-1:0]       b;
        logic [ROB_IDX_W-1:0]   rob;
        logic                   set_nzcv;
        nzcv_t                  nzcv;
        cond_t                  cond;
    } req_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]   rob;
        logic [GPR_W-1:0]       value;
        logic                   set_nzcv;
        nzcv_t                  nzcv;
        logic                   cond_holds;
    } res_t;

    logic [NUM_ALU-1:0] nonempty, pop;
    res_t               head [NUM_ALU];
    logic [LANE_W-1:0]  rr_q, lock_idx_q, gnt, rr_nxt;
    logic               lock_q, done;

    for (genvar g = 0; g < NUM_ALU; g++) begin : g_lane
        req_t               s1_q;
        logic               s1_vld_q, accept;
        res_t               res, mem_q [RESULT_DEPTH];
        logic [PTR_W-1:0]   wr_q, rd_q;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [GPR_W-1:0]   r_value;
        nzcv_t              r_nzcv;
        logic               r_holds;

        // Credit counts the operand stage too, so a push can never overflow.
        assign out_rs_alu_ready[g] = in_rst_n &&
                                     (({1'b0, cnt_q} + (CNT_W+1)'(s1_vld_q)) < DEPTH_C);
        assign accept = in_rs_alu_start[g] && out_rs_alu_ready[g];

        alu_exec #(.GPR_W(GPR_W)) u_exec (
            .op_i         (s1_q.op),
            .a_i          (s1_q.a),
            .b_i          (s1_q.b),
            .set_nzcv_i   (s1_q.set_nzcv),
            .nzcv_i       (s1_q.nzcv),
            .cond_i       (s1_q.cond),
            .result_o     (r_value),
            .nzcv_o       (r_nzcv),
            .cond_holds_o (r_holds)
        );

        assign res = '{rob: s1_q.rob, value: r_value, set_nzcv: s1_q.set_nzcv,
                       nzcv: r_nzcv, cond_holds: r_holds};

        always_comb begin
            cnt_d = cnt_q;
            case ({s1_vld_q, pop[g]})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                s1_vld_q <= 1'b0;
                s1_q     <= '0;
                wr_q     <= '0;
                rd_q     <= '0;
                cnt_q    <= '0;
            end else if (in_flush) begin
                s1_vld_q <= 1'b0;
                wr_q     <= '0;
                rd_q     <= '0;
                cnt_q    <= '0;
            end else begin
                s1_vld_q <= accept;
                if (accept)
                    s1_q <= '{op: in_rs_alu_op[g], a: in_rs_alu_val_a[g],
                              b: in_rs_alu_val_b[g], rob: in_rs_alu_dst_rob_index[g],
                              set_nzcv: in_rs_alu_set_nzcv[g], nzcv: in_rs_alu_nzcv[g],
                              cond: in_rs_alu_cond[g]};
                if (s1_vld_q) wr_q <= wr_q + PTR_W'(1);
                if (pop[g])   rd_q <= rd_q + PTR_W'(1);
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge in_clk) begin
            if (s1_vld_q && !in_flush) mem_q[wr_q] <= res;
        end

        assign head[g]     = mem_q[rd_q];
        assign nonempty[g] = (cnt_q != '0);
        assign pop[g]      = done && in_rob_ready && (gnt == LANE_W'(g));
    end

    assign done = |nonempty;

    // A stalled grant is locked so a newly filled lane cannot steal the port.
    always_comb begin
        int   idx;
        logic found;
        gnt   = lock_idx_q;
        found = lock_q;
        for (int i = 0; i < NUM_ALU; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_ALU) idx = idx - NUM_ALU;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                gnt   = LANE_W'(idx);
            end
        end
        rr_nxt = (gnt == LANE_W'(NUM_ALU - 1)) ? '0 : gnt + LANE_W'(1);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (in_flush) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (done && in_rob_ready) begin
            rr_q   <= rr_nxt;
            lock_q <= 1'b0;
        end else if (done) begin
            lock_q     <= 1'b1;
            lock_idx_q <= gnt;
        end
    end

    assign out_rob_done          = done;
    assign out_rob_dst_rob_index = done ? head[gnt].rob        : '0;
    assign out_rob_value         = done ? head[gnt].value      : '0;
    assign out_rob_set_nzcv      = done ? head[gnt].set_nzcv   : 1'b0;
    assign out_rob_nzcv          = done ? head[gnt].nzcv       : '0;
    assign out_rob_cond_holds    = done ? head[gnt].cond_holds : 1'b0;

endmodule

// File: tb/tb_alu_cluster.sv
// Scoreboard bench for alu_cluster: expected writebacks are queued at issue
// and checked in order by a monitor whenever the ROB accepts a result.
module tb_alu_cluster;
    import alu_cluster_pkg::*;

    localparam int N  = 2;
    localparam int D  = 2;
    localparam int W  = 64;
    localparam int RW = 6;

    logic                   in_clk = 1'b0;
    logic                   in_rst_n, in_flush, in_rob_ready;
    logic [N-1:0]           in_rs_alu_start, in_rs_alu_set_nzcv, out_rs_alu_ready;
    alu_op_t [N-1:0]        in_rs_alu_op;
    logic [N-1:0][W-1:0]    in_rs_alu_val_a, in_rs_alu_val_b;
    logic [N-1:0][RW-1:0]   in_rs_alu_dst_rob_index;
    nzcv_t [N-1:0]          in_rs_alu_nzcv;
    cond_t [N-1:0]          in_rs_alu_cond;
    logic                   out_rob_done, out_rob_set_nzcv, out_rob_cond_holds;
    logic [RW-1:0]          out_rob_dst_rob_index;
    logic [W-1:0]           out_rob_value;
    nzcv_t                  out_rob_nzcv;

    alu_cluster #(.NUM_ALU(N), .RESULT_DEPTH(D), .GPR_W(W), .ROB_IDX_W(RW)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_flush(in_flush),
        .in_rs_alu_start(in_rs_alu_start), .in_rs_alu_op(in_rs_alu_op),
        .in_rs_alu_val_a(in_rs_alu_val_a), .in_rs_alu_val_b(in_rs_alu_val_b),
        .in_rs_alu_dst_rob_index(in_rs_alu_dst_rob_index),
        .in_rs_alu_set_nzcv(in_rs_alu_set_nzcv), .in_rs_alu_nzcv(in_rs_alu_nzcv),
        .in_rs_alu_cond(in_rs_alu_cond), .out_rs_alu_ready(out_rs_alu_ready),
        .in_rob_ready(in_rob_ready), .out_rob_done(out_rob_done),
        .out_rob_dst_rob_index(out_rob_dst_rob_index), .out_rob_value(out_rob_value),
        .out_rob_set_nzcv(out_rob_set_nzcv), .out_rob_nzcv(out_rob_nzcv),
        .out_rob_cond_holds(out_rob_cond_holds)
    );

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [W-1:0]  val;
        logic          set;
        logic [3:0]    nz;
        logic          holds;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0, errors = 0, cyc = 0, last_pop = 0, prev_pop = 0;

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc++;

    always @(negedge in_clk) begin
        wb_t act, e;
        if (out_rob_done && in_rob_ready) begin
            act = '{rob: out_rob_dst_rob_index, val: out_rob_value, set: out_rob_set_nzcv,
                    nz: out_rob_nzcv, holds: out_rob_cond_holds};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rob=%0d val=%h, required no writeback",
                         act.rob, act.val);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL wb_payload: got rob=%0d val=%h set=%b nzcv=%b holds=%b, required rob=%0d val=%h set=%b nzcv=%b holds=%b",
                             act.rob, act.val, act.set, act.nz, act.holds,
                             e.rob, e.val, e.set, e.nz, e.holds);
                end
            end
            prev_pop = last_pop;
            last_pop = cyc;
        end
    end

    task automatic step();
        @(posedge in_clk);
        #1;
        in_rs_alu_start = '0;
    endtask

    task automatic drive(input int lane, input alu_op_t op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [RW-1:0] rob, input logic set,
                         input logic [3:0] nz, input cond_t cond, input logic [W-1:0] ev,
                         input logic [3:0] enz, input logic eh, input bit acc);
        wb_t w;
        in_rs_alu_start[lane]         = 1'b1;
        in_rs_alu_op[lane]            = op;
        in_rs_alu_val_a[lane]         = a;
        in_rs_alu_val_b[lane]         = b;
        in_rs_alu_dst_rob_index[lane] = rob;
        in_rs_alu_set_nzcv[lane]      = set;
        in_rs_alu_nzcv[lane]          = nz;
        in_rs_alu_cond[lane]          = cond;
        w = '{rob: rob, val: ev, set: set, nz: enz, holds: eh};
        if (acc) exp_q.push_back(w);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        in_rst_n = 1'b0; in_flush = 1'b0; in_rob_ready = 1'b0;
        in_rs_alu_start = '0; in_rs_alu_set_nzcv = '0;
        in_rs_alu_val_a = '0; in_rs_alu_val_b = '0; in_rs_alu_dst_rob_index = '0;
        in_rs_alu_nzcv = '0;
        for (int i = 0; i < N; i++) begin
            in_rs_alu_op[i]   = OP_PLUS;
            in_rs_alu_cond[i] = COND_AL;
        end
        repeat (2) @(posedge in_clk);
        #1;
        checks++;
        if (out_rs_alu_ready !== 2'b00 || out_rob_done !== 1'b0 || out_rob_value !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b done=%b value=%h, required 00 0 0",
                     out_rs_alu_ready, out_rob_done, out_rob_value);
        end
        in_rst_n = 1'b1;
        #1;
        checks++;
        if (out_rs_alu_ready !== 2'b11 || out_rob_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b done=%b, required 11 0",
                     out_rs_alu_ready, out_rob_done);
        end
        step();
    endtask

    task automatic test_reset_mid();
        in_rob_ready = 1'b0;
        drive(0, OP_PLUS, 64'd1, 64'd1, 6'd20, 1'b0, 4'd0, COND_AL, 64'd2, 4'd0, 1'b0, 1'b0);
        drive(1, OP_PLUS, 64'd2, 64'd2, 6'd22, 1'b0, 4'd0, COND_AL, 64'd4, 4'd0, 1'b0, 1'b0);
        step();
        step();
        checks++;
        if (out_rob_done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_queued: done=%b, required 1", out_rob_done);
        end
        in_rst_n = 1'b0;
        #1;
        checks++;
        if (out_rob_done !== 1'b0 || out_rs_alu_ready !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_assert: done=%b ready=%b, required 0 00",
                     out_rob_done, out_rs_alu_ready);
        end
        step();
        step();
        in_rst_n = 1'b1;
        #1;
        checks++;
        if (out_rs_alu_ready !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_ready: ready=%b, required 11", out_rs_alu_ready);
        end
        in_rob_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (out_rob_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale: done=%b, required 0", out_rob_done);
        end
    endtask

    task automatic test_flags();
        in_rob_ready = 1'b1;
        drive(0, OP_PLUS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd5, 1'b1, 4'b0000, COND_AL,
              64'h8000_0000_0000_0000, 4'b1001, 1'b0, 1'b1);
        step();
        checks++;
        if (out_rob_done !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: done=%b one cycle after issue, required 0", out_rob_done);
        end
        step();
        checks++;
        if (out_rob_done !== 1'b1) begin
            errors++;
            $display("FAIL latency_done: done=%b two cycles after issue, required 1", out_rob_done);
        end
        wait_drain("plus_ovf");
        drive(0, OP_MINUS, 64'd5, 64'd5, 6'd6, 1'b1, 4'b0000, COND_AL,
              64'd0, 4'b0110, 1'b0, 1'b1);
        step();
        wait_drain("minus_zero");
    endtask

    task automatic test_rr();
        // start from a known round-robin pointer
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        in_rob_ready = 1'b1;
        drive(0, OP_OR,  64'h0F, 64'hF0, 6'd3, 1'b0, 4'b0000, COND_AL, 64'hFF, 4'b0000, 1'b0, 1'b1);
        drive(1, OP_AND, 64'hFF, 64'h3C, 6'd7, 1'b1, 4'b1111, COND_AL, 64'h3C, 4'b0000, 1'b0, 1'b1);
        step();
        wait_drain("rr_pair1");
        checks++;
        if (last_pop - prev_pop != 1) begin
            errors++;
            $display("FAIL rr_consecutive: gap=%0d cycles, required 1", last_pop - prev_pop);
        end
        drive(0, OP_EOR, 64'hAA, 64'hFF, 6'd1, 1'b0, 4'b0000, COND_AL, 64'h55, 4'b0000, 1'b0, 1'b1);
        step();
        wait_drain("rr_single");
        drive(1, OP_MINUS, 64'd3, 64'd5, 6'd9, 1'b1, 4'b0000, COND_AL,
              64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0, 1'b1);
        drive(0, OP_PLUS, 64'd2, 64'd2, 6'd4, 1'b0, 4'b0011, COND_AL, 64'd4, 4'b0011, 1'b0, 1'b1);
        step();
        wait_drain("rr_pair2");
        checks++;
        if (last_pop - prev_pop != 1) begin
            errors++;
            $display("FAIL rr_consecutive2: gap=%0d cycles, required 1", last_pop - prev_pop);
        end
    endtask

    task automatic test_backpressure();
        in_rob_ready = 1'b0;
        drive(0, OP_PLUS, 64'd1, 64'd1, 6'd10, 1'b0, 4'b0000, COND_AL, 64'd2, 4'b0000, 1'b0, 1'b1);
        step();
        checks++;
        if (out_rs_alu_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready1: ready=%b after 1 accept, required 1", out_rs_alu_ready[0]);
        end
        drive(0, OP_PLUS, 64'd2, 64'd2, 6'd11, 1'b0, 4'b0000, COND_AL, 64'd4, 4'b0000, 1'b0, 1'b1);
        step();
        checks++;
        if (out_rs_alu_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready2: ready=%b after 2 accepts, required 0", out_rs_alu_ready[0]);
        end
        drive(0, OP_PLUS, 64'd3, 64'd3, 6'd12, 1'b0, 4'b0000, COND_AL, 64'd6, 4'b0000, 1'b0, 1'b0);
        step();
        repeat (3) step();
        checks++;
        if (out_rob_done !== 1'b1 || out_rob_dst_rob_index !== 6'd10 || out_rob_value !== 64'd2) begin
            errors++;
            $display("FAIL bp_hold: done=%b rob=%0d val=%h, required 1 10 2",
                     out_rob_done, out_rob_dst_rob_index, out_rob_value);
        end
        checks++;
        if (out_rs_alu_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_ready: ready=%b while stalled, required 0", out_rs_alu_ready[0]);
        end
        in_rob_ready = 1'b1;
        wait_drain("bp");
        checks++;
        if (out_rs_alu_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_back: ready=%b after drain, required 1", out_rs_alu_ready[0]);
        end
    endtask

    task automatic test_csinc();
        in_rob_ready = 1'b1;
        drive(1, OP_CSINC, 64'd10, 64'd20, 6'd13, 1'b0, 4'b0100, COND_EQ,
              64'd10, 4'b0100, 1'b1, 1'b1);
        step();
        drive(1, OP_CSINC, 64'd10, 64'd20, 6'd14, 1'b0, 4'b0000, COND_EQ,
              64'd21, 4'b0000, 1'b0, 1'b1);
        step();
        wait_drain("csinc");
    endtask

    task automatic test_flush();
        in_rob_ready = 1'b0;
        drive(0, OP_PLUS, 64'd1, 64'd2, 6'd15, 1'b0, 4'b0000, COND_AL, 64'd3, 4'b0000, 1'b0, 1'b0);
        step();
        drive(0, OP_PLUS, 64'd3, 64'd4, 6'd16, 1'b0, 4'b0000, COND_AL, 64'd7, 4'b0000, 1'b0, 1'b0);
        step();
        drive(1, OP_OR, 64'd1, 64'd2, 6'd17, 1'b0, 4'b0000, COND_AL, 64'd3, 4'b0000, 1'b0, 1'b0);
        step();
        in_flush = 1'b1;
        drive(1, OP_PLUS, 64'd9, 64'd9, 6'd18, 1'b0, 4'b0000, COND_AL, 64'd18, 4'b0000, 1'b0, 1'b0);
        step();
        in_flush = 1'b0;
        checks++;
        if (out_rob_done !== 1'b0 || out_rs_alu_ready !== 2'b11) begin
            errors++;
            $display("FAIL flush_state: done=%b ready=%b, required 0 11",
                     out_rob_done, out_rs_alu_ready);
        end
        in_rob_ready = 1'b1;
        drive(1, OP_PLUS, 64'd7, 64'd8, 6'd21, 1'b1, 4'b0000, COND_AL, 64'd15, 4'b0000, 1'b0, 1'b1);
        step();
        wait_drain("flush_after");
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_flags();
        test_rr();
        test_backpressure();
        test_csinc();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
